// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: FWFT fetch-to-decode instruction queue with flush and keep-head (delay slot) redirect
module inst_fetch_queue #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               push_adel,
  output logic               pop_valid,
  input  logic               pop_ready,
  output logic [PC_W-1:0]    pop_pc,
  output logic [INSTR_W-1:0] pop_instr,
  output logic               pop_adel,
  input  logic               flush,
  input  logic               flush_keep,
  output logic [CNT_W-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_W + INSTR_W + 1;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] hold;
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic push_fire, pop_fire, keep, keep_one;
  assign pop_valid  = count != '0;
  assign push_ready = count != CNT_W'(DEPTH);
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;
  assign {pop_pc, pop_instr, pop_adel} = pop_valid ? mem[rd_ptr] : hold;
  assign keep     = flush_keep & pop_valid;
  assign keep_one = keep & (~pop_fire | (count > CNT_W'(1)));
  assign rd_nxt   = rd_ptr + AW'(pop_fire);
  always_ff @(posedge clk)
    if (!rst && !flush && push_fire) mem[wr_ptr] <= {push_pc, push_instr, push_adel};
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (pop_valid) hold <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= keep ? rd_nxt : rd_ptr;
        wr_ptr <= keep ? rd_nxt + AW'(keep_one) : rd_ptr;
        count  <= CNT_W'(keep_one);
      end else begin
        rd_ptr <= rd_nxt;
        wr_ptr <= wr_ptr + AW'(push_fire);
        count  <= count + CNT_W'(push_fire) - CNT_W'(pop_fire);
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
  logic clk = 0, rst = 1, push_valid = 0, pop_ready = 0, push_adel = 0, flush = 0, flush_keep = 0;
  logic [31:0] push_pc = '0, push_instr = '0, pop_pc, pop_instr;
  logic push_ready, pop_valid, pop_adel;
  logic [2:0] count;
  int n_cmp = 0, n_err = 0;
  inst_fetch_queue dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_pc(push_pc), .push_instr(push_instr), .push_adel(push_adel),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_pc(pop_pc),
    .pop_instr(pop_instr), .pop_adel(pop_adel), .flush(flush),
    .flush_keep(flush_keep), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [31:0] pc, input logic adel);
    push_valid = 1;
    push_pc = pc;
    push_instr = ~pc;
    push_adel = adel;
    tick();
    push_valid = 0;
    push_adel = 0;
  endtask
  task automatic pop1();
    pop_ready = 1;
    tick();
    pop_ready = 0;
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_pop_pc", pop_pc, 0);
    push1(32'hBFC00000, 0);
    chk("lat_pop_valid", 32'(pop_valid), 1);
    chk("lat_pop_pc", pop_pc, 32'hBFC00000);
    push1(32'hBFC00004, 0);
    chk("t1_count", 32'(count), 2);
    chk("t1_pop_pc", pop_pc, 32'hBFC00000);
    chk("t1_pop_instr", pop_instr, ~32'hBFC00000);
    chk("t1_push_ready", 32'(push_ready), 1);
    pop1();
    chk("t1_pop2", pop_pc, 32'hBFC00004);
    pop1();
    chk("t1_drain", 32'(count), 0);
    pop1();
    chk("underflow_count", 32'(count), 0);
    chk("underflow_hold", pop_pc, 32'hBFC00004);
    for (int i = 0; i < 5; i++) begin
      push1(32'h200 + 32'(4 * i), 0);
      chk("t2_ready", 32'(push_ready), 32'(i < 3));
    end
    chk("t2_full_count", 32'(count), 4);
    chk("t2_head0", pop_pc, 32'h200);
    push_valid = 1;
    push_pc = 32'h300;
    pop1();
    push_valid = 0;
    chk("t2_full_pop_push", 32'(count), 3);
    for (int i = 1; i < 4; i++) begin
      chk("t2_order", pop_pc, 32'h200 + 32'(4 * i));
      pop1();
    end
    chk("t2_empty", 32'(count), 0);
    push1(32'h400, 0);
    push1(32'h404, 0);
    push_valid = 1;
    pop_ready = 1;
    for (int i = 0; i < 8; i++) begin
      push_pc = 32'h408 + 32'(4 * i);
      chk("t3_order", pop_pc, 32'h400 + 32'(4 * i));
      tick();
      chk("t3_count", 32'(count), 2);
    end
    push_valid = 0;
    pop_ready = 0;
    chk("t3_head", pop_pc, 32'h420);
    flush = 1;
    tick();
    flush = 0;
    chk("t3_flush", 32'(count), 0);
    push1(32'h100, 0);
    push1(32'h104, 0);
    flush = 1;
    push_valid = 1;
    push_pc = 32'h108;
    tick();
    flush = 0;
    push_valid = 0;
    chk("t5_count", 32'(count), 0);
    chk("t5_pop_valid", 32'(pop_valid), 0);
    tick();
    chk("t5_dropped", 32'(count), 0);
    push1(32'h100, 0);
    push1(32'h104, 0);
    push1(32'h108, 0);
    flush = 1;
    flush_keep = 1;
    push_valid = 1;
    push_pc = 32'h10C;
    tick();
    flush = 0;
    flush_keep = 0;
    push_valid = 0;
    chk("t4_count", 32'(count), 1);
    chk("t4_head", pop_pc, 32'h100);
    push1(32'h500, 0);
    pop1();
    chk("t4_next", pop_pc, 32'h500);
    pop1();
    push1(32'hA0, 0);
    push1(32'hA4, 0);
    push1(32'hA8, 0);
    flush = 1;
    flush_keep = 1;
    pop1();
    chk("keep_pop_count", 32'(count), 1);
    chk("keep_pop_head", pop_pc, 32'hA4);
    pop1();
    chk("keep_pop_last", 32'(count), 0);
    push1(32'hB0, 0);
    chk("keep_empty", 32'(count), 0);
    flush = 0;
    push1(32'hC0, 0);
    push1(32'hC4, 0);
    flush_keep = 0;
    chk("keep_noflush", 32'(count), 2);
    pop1();
    pop1();
    push1(32'h601, 1);
    chk("t6_adel", 32'(pop_adel), 1);
    push1(32'h604, 0);
    push1(32'h608, 0);
    chk("t6_count", 32'(count), 3);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_pop_valid", 32'(pop_valid), 0);
    chk("t6_rst_push_ready", 32'(push_ready), 1);
    chk("t6_rst_pop_pc", pop_pc, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
